// File: rtl/pmpadrenc.sv
// PMP region encoder: picks NA4/NAPOT/TOR for a [base,bound) region and issues pmpaddr/pmpcfg writes.
// Latency: 2 cycles accept->done on reject; 4 (single entry) or 6 (TOR pair) cycles with no write stalls.
// Backpressure: each write beat holds until WrReady; ReqReady only in IDLE. Option: PMPADRENC_LOCK_CHECK_EN.

package pmpadrenc_pkg;
  typedef struct packed {
    int PA_BITS;
    int PMP_ENTRIES;
  } cvw_t;
endpackage

module pmpadrenc
  import pmpadrenc_pkg::*;
#(
  parameter cvw_t P = '{PA_BITS: 34, PMP_ENTRIES: 16}
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               ReqValid,
  output logic                               ReqReady,
  input  logic [P.PA_BITS-1:0]               ReqBase,
  input  logic [P.PA_BITS:0]                 ReqBound,
  input  logic [$clog2(P.PMP_ENTRIES)-1:0]   ReqIndex,
  input  logic [2:0]                         ReqPerm,
  input  logic                               ReqLock,
`ifdef PMPADRENC_LOCK_CHECK_EN
  input  logic [P.PMP_ENTRIES-1:0]           LockedEntries,
`endif
  output logic                               WrValid,
  input  logic                               WrReady,
  output logic                               WrIsCfg,
  output logic [$clog2(P.PMP_ENTRIES)-1:0]   WrIndex,
  output logic [P.PA_BITS-3:0]               WrAdr,
  output logic [7:0]                         WrCfg,
  output logic                               DoneValid,
  output logic                               DoneError,
  output logic [1:0]                         DoneMode
);

  localparam int PA = P.PA_BITS;
  localparam int NE = P.PMP_ENTRIES;
  localparam int IW = $clog2(NE);

  localparam logic [1:0] MODE_TOR   = 2'b01;
  localparam logic [1:0] MODE_NA4   = 2'b10;
  localparam logic [1:0] MODE_NAPOT = 2'b11;

  localparam logic [PA:0]   SIZE_ONE   = (PA+1)'(1);
  localparam logic [PA:0]   SIZE_FOUR  = (PA+1)'(4);
  localparam logic [PA:0]   SIZE_EIGHT = (PA+1)'(8);
  localparam logic [PA-3:0] MASK_ONE   = (PA-2)'(1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NE-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASSIFY,
    S_ADR0,
    S_CFG0,
    S_ADR1,
    S_CFG1,
    S_DONE
  } state_t;

  state_t          state_q, state_d;

  // Captured request
  logic [PA-1:0]   base_q;
  logic [PA:0]     bound_q;
  logic [IW-1:0]   index_q;
  logic [2:0]      perm_q;
  logic            lock_q;

  // Classification result, held for the write beats and the done pulse
  logic [1:0]      mode_q;
  logic            err_q;
  logic [PA-3:0]   adr1_q;
  logic [IW-1:0]   idx1_q;

  // Classification datapath (only meaningful in CLASSIFY)
  logic [PA:0]     region_size;
  logic [PA:0]     size_m1;
  logic [PA-3:0]   napot_mask;
  logic            bad_range;
  logic            is_na4;
  logic            is_napot;
  logic            tor_single;
  logic            cls_err;
  logic            cls_pair;
  logic [1:0]      cls_mode;
  logic [PA-3:0]   cls_adr1;
  logic [IW-1:0]   cls_idx1;
`ifdef PMPADRENC_LOCK_CHECK_EN
  logic [IW:0]     idx2_wide;
  logic            idx2_exists;
`endif

  // Pick the cheapest mode for the captured region and precompute the last address beat
  always_comb begin
    region_size = bound_q - {1'b0, base_q};
    size_m1     = region_size - SIZE_ONE;
    napot_mask  = region_size[PA:3] - MASK_ONE;
    bad_range   = (bound_q <= {1'b0, base_q}) || (base_q[1:0] != 2'b00) || (bound_q[1:0] != 2'b00);
    is_na4      = (region_size == SIZE_FOUR);
    is_napot    = (region_size >= SIZE_EIGHT) && ((region_size & size_m1) == '0)
                  && (({1'b0, base_q} & size_m1) == '0);
    tor_single  = (base_q == '0) && (index_q == '0);

    cls_err  = 1'b0;
    cls_pair = 1'b0;
    cls_mode = MODE_TOR;
    cls_adr1 = bound_q[PA-1:2];
    cls_idx1 = index_q;

    if (bad_range) begin
      cls_err = 1'b1;
    end else if (is_na4) begin
      cls_mode = MODE_NA4;
      cls_adr1 = base_q[PA-1:2];
    end else if (is_napot) begin
      cls_mode = MODE_NAPOT;
      cls_adr1 = base_q[PA-1:2] | napot_mask;
    end else begin
      // A TOR region starting at 0 in entry 0 needs no lower-bound entry
      cls_pair = !tor_single;
      if (cls_pair) begin
        cls_idx1 = index_q + IDX_ONE;
      end
      // Bound beyond the physical space is unrepresentable; a pair at the last entry has no room
      if (bound_q[PA] || (cls_pair && (index_q == LAST_IDX))) begin
        cls_err = 1'b1;
      end
    end

`ifdef PMPADRENC_LOCK_CHECK_EN
    idx2_wide   = {1'b0, index_q} + (IW+1)'(2);
    idx2_exists = (idx2_wide < (IW+1)'(NE));
    if (LockedEntries[index_q]) begin
      cls_err = 1'b1;
    end
    if (cls_pair) begin
      if (LockedEntries[cls_idx1]) begin
        cls_err = 1'b1;
      end
      // A locked TOR entry above would freeze our upper pmpaddr. Its mode is not visible
      // here, so a locked neighbour is treated as TOR.
      if (idx2_exists && LockedEntries[idx2_wide[IW-1:0]]) begin
        cls_err = 1'b1;
      end
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the request on accept and the classification result in CLASSIFY
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q  <= '0;
      bound_q <= '0;
      index_q <= '0;
      perm_q  <= '0;
      lock_q  <= 1'b0;
      mode_q  <= '0;
      err_q   <= 1'b0;
      adr1_q  <= '0;
      idx1_q  <= '0;
    end else begin
      if ((state_q == S_IDLE) && ReqValid) begin
        base_q  <= ReqBase;
        bound_q <= ReqBound;
        index_q <= ReqIndex;
        perm_q  <= ReqPerm;
        lock_q  <= ReqLock;
      end
      if (state_q == S_CLASSIFY) begin
        mode_q <= cls_err ? 2'b00 : cls_mode;
        err_q  <= cls_err;
        adr1_q <= cls_adr1;
        idx1_q <= cls_idx1;
      end
    end
  end

  // Next state and beat/done outputs; the active cfg byte is always the final beat
  always_comb begin
    state_d   = state_q;
    ReqReady  = 1'b0;
    WrValid   = 1'b0;
    WrIsCfg   = 1'b0;
    WrIndex   = '0;
    WrAdr     = '0;
    WrCfg     = '0;
    DoneValid = 1'b0;
    DoneError = 1'b0;
    DoneMode  = 2'b00;

    case (state_q)
      S_IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) state_d = S_CLASSIFY;
      end
      S_CLASSIFY: begin
        if (cls_err)       state_d = S_DONE;
        else if (cls_pair) state_d = S_ADR0;
        else               state_d = S_ADR1;
      end
      S_ADR0: begin
        WrValid = 1'b1;
        WrIndex = index_q;
        WrAdr   = base_q[PA-1:2];
        if (WrReady) state_d = S_CFG0;
      end
      S_CFG0: begin
        WrValid = 1'b1;
        WrIsCfg = 1'b1;
        WrIndex = index_q;
        WrCfg   = 8'h00;
        if (WrReady) state_d = S_ADR1;
      end
      S_ADR1: begin
        WrValid = 1'b1;
        WrIndex = idx1_q;
        WrAdr   = adr1_q;
        if (WrReady) state_d = S_CFG1;
      end
      S_CFG1: begin
        WrValid = 1'b1;
        WrIsCfg = 1'b1;
        WrIndex = idx1_q;
        WrCfg   = {lock_q, 2'b00, mode_q, perm_q};
        if (WrReady) state_d = S_DONE;
      end
      S_DONE: begin
        DoneValid = 1'b1;
        DoneError = err_q;
        DoneMode  = mode_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pmpadrenc.sv
// Scoreboard bench for pmpadrenc with PA_BITS=34, 16 PMP entries.
// Expected beats/completions are queued at stimulus time and popped by a negedge monitor.
// Covers reset state, NA4/NAPOT/TOR encodings, rejects, backpressure and mid-request reset.

module tb_pmpadrenc;
  import pmpadrenc_pkg::*;

  localparam cvw_t P = '{PA_BITS: 34, PMP_ENTRIES: 16};

  logic        clk = 1'b0;
  logic        reset;
  logic        ReqValid;
  logic        ReqReady;
  logic [33:0] ReqBase;
  logic [34:0] ReqBound;
  logic [3:0]  ReqIndex;
  logic [2:0]  ReqPerm;
  logic        ReqLock;
`ifdef PMPADRENC_LOCK_CHECK_EN
  logic [15:0] LockedEntries;
`endif
  logic        WrValid;
  logic        WrReady;
  logic        WrIsCfg;
  logic [3:0]  WrIndex;
  logic [31:0] WrAdr;
  logic [7:0]  WrCfg;
  logic        DoneValid;
  logic        DoneError;
  logic [1:0]  DoneMode;

  pmpadrenc #(.P(P)) dut (
    .clk           (clk),
    .reset         (reset),
    .ReqValid      (ReqValid),
    .ReqReady      (ReqReady),
    .ReqBase       (ReqBase),
    .ReqBound      (ReqBound),
    .ReqIndex      (ReqIndex),
    .ReqPerm       (ReqPerm),
    .ReqLock       (ReqLock),
`ifdef PMPADRENC_LOCK_CHECK_EN
    .LockedEntries (LockedEntries),
`endif
    .WrValid       (WrValid),
    .WrReady       (WrReady),
    .WrIsCfg       (WrIsCfg),
    .WrIndex       (WrIndex),
    .WrAdr         (WrAdr),
    .WrCfg         (WrCfg),
    .DoneValid     (DoneValid),
    .DoneError     (DoneError),
    .DoneMode      (DoneMode)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_cfg;
    logic [3:0]  idx;
    logic [31:0] adr;
    logic [7:0]  cfg;
  } beat_t;

  typedef struct packed {
    logic       err;
    logic [1:0] mode;
  } done_t;

  beat_t beat_q[$];
  done_t done_q[$];
  beat_t mb;
  done_t md;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push_adr(input logic [3:0] idx, input logic [31:0] adr);
    beat_q.push_back('{is_cfg: 1'b0, idx: idx, adr: adr, cfg: 8'h00});
  endtask

  task automatic push_cfg(input logic [3:0] idx, input logic [7:0] cfg);
    beat_q.push_back('{is_cfg: 1'b1, idx: idx, adr: 32'h0, cfg: cfg});
  endtask

  task automatic push_done(input logic err, input logic [1:0] mode);
    done_q.push_back('{err: err, mode: mode});
  endtask

  // Monitor: every transferred beat and every completion must match the queue head
  always @(negedge clk) begin
    if (WrValid && WrReady) begin
      if (beat_q.size() == 0) begin
        check("beat_unexpected", {WrIsCfg, WrIndex}, 5'h00);
      end else begin
        mb = beat_q.pop_front();
        check("beat_kind", WrIsCfg, mb.is_cfg);
        check("beat_idx", WrIndex, mb.idx);
        if (mb.is_cfg) check("beat_cfg", WrCfg, mb.cfg);
        else           check("beat_adr", WrAdr, mb.adr);
      end
    end
    if (DoneValid) begin
      if (done_q.size() == 0) begin
        check("done_unexpected", DoneValid, 1'b0);
      end else begin
        md = done_q.pop_front();
        check("done_err", DoneError, md.err);
        check("done_mode", DoneMode, md.mode);
      end
    end
  end

  // Issue one request from IDLE and wait (bounded) for its completion pulse
  task automatic send(input logic [33:0] base, input logic [34:0] bound, input logic [3:0] idx,
                      input logic [2:0] perm, input logic lock, output int lat);
    check("req_ready", ReqReady, 1'b1);
    ReqBase  = base;
    ReqBound = bound;
    ReqIndex = idx;
    ReqPerm  = perm;
    ReqLock  = lock;
    ReqValid = 1'b1;
    @(posedge clk); #1;
    ReqValid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (DoneValid) begin
        lat = n;
        break;
      end
    end
    check("done_seen", DoneValid, 1'b1);
    @(posedge clk); #1;
  endtask

  int lat;

  initial begin
    reset    = 1'b1;
    ReqValid = 1'b0;
    ReqBase  = '0;
    ReqBound = '0;
    ReqIndex = '0;
    ReqPerm  = '0;
    ReqLock  = 1'b0;
    WrReady  = 1'b1;
`ifdef PMPADRENC_LOCK_CHECK_EN
    LockedEntries = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", ReqReady, 1'b1);
    check("rst_wr_valid", WrValid, 1'b0);
    check("rst_done_valid", DoneValid, 1'b0);
    check("rst_done_error", DoneError, 1'b0);
    check("rst_done_mode", DoneMode, 2'b00);
    check("rst_wr_fields", {WrIsCfg, WrIndex, WrAdr, WrCfg}, 45'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // NA4
    push_adr(4'd3, 32'h2000_0004); push_cfg(4'd3, 8'h13); push_done(1'b0, 2'b10);
    send(34'h0_8000_0010, 35'h0_8000_0014, 4'd3, 3'b011, 1'b0, lat);
    check("na4_lat", lat, 4);

    // NAPOT
    push_adr(4'd1, 32'h2000_01FF); push_cfg(4'd1, 8'h1C); push_done(1'b0, 2'b11);
    send(34'h0_8000_0000, 35'h0_8000_1000, 4'd1, 3'b100, 1'b0, lat);

    // Smallest NAPOT region (8 bytes), locked
    push_adr(4'd5, 32'h2000_0002); push_cfg(4'd5, 8'h9D); push_done(1'b0, 2'b11);
    send(34'h0_8000_0008, 35'h0_8000_0010, 4'd5, 3'b101, 1'b1, lat);

    // TOR pair: lower bound entry is written and switched off before the active entry
    push_adr(4'd2, 32'h2000_0400); push_cfg(4'd2, 8'h00);
    push_adr(4'd3, 32'h2000_0700); push_cfg(4'd3, 8'h89); push_done(1'b0, 2'b01);
    send(34'h0_8000_1000, 35'h0_8000_1C00, 4'd2, 3'b001, 1'b1, lat);
    check("tor_pair_lat", lat, 6);

    // TOR single: base 0 in entry 0
    push_adr(4'd0, 32'h0000_0700); push_cfg(4'd0, 8'h0F); push_done(1'b0, 2'b01);
    send(34'h0, 35'h0_0000_1C00, 4'd0, 3'b111, 1'b0, lat);
    check("tor_single_lat", lat, 4);

    // Rejects: no beats, completion two cycles after accept
    push_done(1'b1, 2'b00);
    send(34'h100, 35'h100, 4'd0, 3'b001, 1'b0, lat);
    check("err_empty_lat", lat, 2);
    push_done(1'b1, 2'b00);
    send(34'h102, 35'h200, 4'd0, 3'b001, 1'b0, lat);
    check("err_misalign_lat", lat, 2);
    push_done(1'b1, 2'b00);
    send(34'h200, 35'h100, 4'd0, 3'b001, 1'b0, lat);
    check("err_inverted_lat", lat, 2);
    push_done(1'b1, 2'b00);
    send(34'h0_8000_1000, 35'h0_8000_1C00, 4'd15, 3'b001, 1'b0, lat);
    check("err_last_pair_lat", lat, 2);
    push_done(1'b1, 2'b00);
    send(34'h1000, 35'h4_0000_0000, 4'd4, 3'b001, 1'b0, lat);
    check("err_bound_top_lat", lat, 2);

`ifdef PMPADRENC_LOCK_CHECK_EN
    LockedEntries = 16'h0008;
    push_done(1'b1, 2'b00);
    send(34'h0_8000_0010, 35'h0_8000_0014, 4'd3, 3'b011, 1'b0, lat);
    check("err_locked_lat", lat, 2);
    LockedEntries = '0;
`endif

    // Backpressure on the NAPOT address beat, then reset while the cfg beat is pending.
    // Only the address beat is expected; the aborted request must not complete.
    WrReady = 1'b0;
    push_adr(4'd1, 32'h2000_01FF);
    check("bp_req_ready", ReqReady, 1'b1);
    ReqBase  = 34'h0_8000_0000;
    ReqBound = 35'h0_8000_1000;
    ReqIndex = 4'd1;
    ReqPerm  = 3'b100;
    ReqLock  = 1'b0;
    ReqValid = 1'b1;
    @(posedge clk); #1;
    ReqValid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_wr_valid", WrValid, 1'b1);
      check("bp_wr_adr", WrAdr, 32'h2000_01FF);
      check("bp_wr_kind", WrIsCfg, 1'b0);
      check("bp_req_busy", ReqReady, 1'b0);
    end
    @(posedge clk); #1;
    WrReady = 1'b1;
    @(posedge clk); #1;
    WrReady = 1'b0;
    @(negedge clk);
    check("cfg1_wr_valid", WrValid, 1'b1);
    check("cfg1_wr_kind", WrIsCfg, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_wr_valid", WrValid, 1'b1);
    @(negedge clk);
    check("rst_abort_wr_valid", WrValid, 1'b0);
    check("rst_abort_ready", ReqReady, 1'b1);
    check("rst_abort_done", DoneValid, 1'b0);
    @(posedge clk); #1;
    reset   = 1'b0;
    WrReady = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Back-to-back after the abort
    push_adr(4'd3, 32'h2000_0004); push_cfg(4'd3, 8'h13); push_done(1'b0, 2'b10);
    send(34'h0_8000_0010, 35'h0_8000_0014, 4'd3, 3'b011, 1'b0, lat);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("beats_left", beat_q.size(), 0);
    check("dones_left", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
